// File: rtl/piano_pkg.sv
// Shared constants for the piano tone generator: clock rate, terminal-count
// width, per-note half-period terminal counts and note index names.
package piano_pkg;

   localparam int CLK_HZ = 50_000_000;
   localparam int TCW    = 19;

   typedef enum logic [2:0] {
      NOTE_C4 = 3'd0,
      NOTE_D4 = 3'd1,
      NOTE_E4 = 3'd2,
      NOTE_F4 = 3'd3,
      NOTE_G4 = 3'd4,
      NOTE_A4 = 3'd5,
      NOTE_B4 = 3'd6,
      NOTE_C5 = 3'd7
   } note_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_e;

   // round(CLK_HZ / (2 * f_note)); the divider counts 0..TC and toggles on wrap
   localparam logic [TCW-1:0] NOTE_TC [8] = '{
      19'd95556,  // C4
      19'd85131,  // D4
      19'd75843,  // E4
      19'd71586,  // F4
      19'd63776,  // G4
      19'd56818,  // A4
      19'd50619,  // B4
      19'd47778   // C5
   };

endpackage

// File: rtl/piano_key_debounce.sv
// Single-key conditioner: 2-FF synchroniser, stability counter and stable
// level, plus one-cycle press/release pulses derived from the stable level.
module key_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_i,
   output logic stable_o,
   output logic press_o,
   output logic release_o
);

   localparam int CNTW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEB_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_prev_q;
   logic [CNTW-1:0] cnt_q;

   // Synchronise the raw level, then accept a change only after it has been
   // seen continuously for DEB_CYCLES samples; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         sync1_q       <= key_i;
         sync2_q       <= sync1_q;
         stable_prev_q <= stable_q;
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign stable_o  = stable_q;
   assign press_o   = stable_q & ~stable_prev_q;
   assign release_o = ~stable_q & stable_prev_q;

endmodule

// File: rtl/piano_key_select.sv
// Key arbiter: debounces every key and selects one note using
// last-pressed-wins, with fallback to the lowest held key on release.
module piano_key_select #(
   parameter int NKEYS      = 8,
   parameter int DEB_CYCLES = 500000,
   parameter int TCW        = piano_pkg::TCW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NKEYS-1:0] keys,
   output logic             note_on,
   output logic [2:0]       note_idx,
   output logic [TCW-1:0]   half_period,
   output logic             note_strobe
);

   import piano_pkg::*;

   logic [NKEYS-1:0] stable, press, rls;

   for (genvar g = 0; g < NKEYS; g++) begin : g_key
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk       (clk),
         .rst       (rst),
         .key_i     (keys[g]),
         .stable_o  (stable[g]),
         .press_o   (press[g]),
         .release_o (rls[g])
      );
   end

   function automatic logic [2:0] lowest(input logic [NKEYS-1:0] v);
      logic [2:0] r;
      r = '0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [TCW-1:0]   hp_q, hp_d;
   logic             strobe_q, strobe_d;

   // Arbitration: a new press always wins; releasing the active key falls
   // back to the lowest held key, or goes idle when nothing is held.
   // In idle the last index is kept so only note_on and half_period move.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (|press) begin
               state_d = ST_PLAY;
               idx_d   = lowest(press);
            end
         end
         ST_PLAY: begin
            if (|press) begin
               idx_d = lowest(press);
            end else if (rls[idx_q]) begin
               if (|stable) idx_d = lowest(stable);
               else         state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      strobe_d = (state_d != state_q) || (idx_d != idx_q);
      hp_d     = (state_d == ST_PLAY) ? TCW'(NOTE_TC[idx_d]) : '0;
   end

   // Output registers; everything returns to silence on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         hp_q     <= '0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         hp_q     <= hp_d;
         strobe_q <= strobe_d;
      end
   end

   assign note_on     = (state_q == ST_PLAY);
   assign note_idx    = idx_q;
   assign half_period = hp_q;
   assign note_strobe = strobe_q;

endmodule
